// File: rtl/jtframe_zero.sv
// Single-zero FIR pre-emphasis filter: y[k] = x[k] - a*x[k-1], a = a_in/2^WA.
// The product is built with one shift-add step per coefficient bit, so no DSP block is used.
module jtframe_zero #(
  parameter int WS = 16,
  parameter int WA = WS/2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample,
  input  logic [WS-1:0] sin,
  input  logic [WA-1:0] a,
  output logic [WS-1:0] sout,
  output logic          sout_valid,
  output logic          busy,
  output logic          drop
);

  localparam int CW = (WA > 1) ? $clog2(WA) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WS-1:0]    x;
  logic [WS-1:0]    x_prev;
  logic [WA-1:0]    a_l;
  logic [WS+WA-1:0] acc;

  logic [WS+WA-1:0] xext;
  logic [WS+WA-1:0] addend;
  logic [WS-1:0]    p;
  logic [WS:0]      diff;
  logic [WS-1:0]    dsat;

  // Taking the top WS bits of acc is the arithmetic shift by WA, i.e. floor toward -inf
  always_comb begin
    xext   = {{WA{x_prev[WS-1]}}, x_prev};
    addend = xext << cnt;
    p      = acc[WS+WA-1:WA];
    diff   = {x[WS-1], x} - {p[WS-1], p};
    dsat   = diff[WS-1:0];
    if (diff[WS] != diff[WS-1])
      dsat = diff[WS] ? {1'b1, {(WS-1){1'b0}}} : {1'b0, {(WS-1){1'b1}}};
  end

  assign busy = (state != IDLE);

  // A sample that lands while busy is ignored entirely; only the drop pulse records it
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      x          <= '0;
      x_prev     <= '0;
      a_l        <= '0;
      acc        <= '0;
      sout       <= '0;
      sout_valid <= 1'b0;
      drop       <= 1'b0;
    end else begin
      sout_valid <= 1'b0;
      drop       <= sample && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample) begin
            x     <= sin;
            a_l   <= a;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          if (a_l[cnt]) acc <= acc + addend;
          if (cnt == CW'(WA-1)) state <= OUT;
          else                  cnt   <= cnt + 1'b1;
        end
        OUT: begin
          sout       <= dsat;
          sout_valid <= 1'b1;
          x_prev     <= x;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
